// File: rtl/bitwise_decoder.sv
// Recovers operand bits (a, b) from 8-bit operator result vectors and packs them into WORD_W-bit words.
// Optional BITWISE_DEC_ERRCNT_EN builds a saturating 16-bit count of rejected vectors.
module bitwise_decoder #(
    parameter int WORD_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [7:0]        y_vec_in,
    input  logic              y_valid_in,
    output logic              y_ready_out,
    input  logic              flush_in,
    output logic [WORD_W-1:0] a_word_out,
    output logic [WORD_W-1:0] b_word_out,
    output logic              word_valid_out,
    input  logic              word_ready_in,
    output logic              err_out,
    output logic [15:0]       err_cnt_out
);
    localparam int CW = $clog2(WORD_W + 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [WORD_W-1:0] a_word_q, a_word_d, b_word_q, b_word_d;
    logic              err_q, err_d;

    logic              dec_a, dec_b, good, accept;
    logic [7:0]        exp_vec;
    logic [WORD_W-1:0] a_ins, b_ins;

    always_comb begin
        dec_a   = y_vec_in[7];
        dec_b   = dec_a ? y_vec_in[0] : y_vec_in[1];
        exp_vec = {dec_a, ~(dec_a | dec_b), ~(dec_a & dec_b), ~dec_a,
                   ~(dec_a ^ dec_b), dec_a ^ dec_b, dec_a | dec_b, dec_a & dec_b};
        good    = (exp_vec == y_vec_in);

        y_ready_out = (state_q == COLLECT) ? ~flush_in : (word_ready_in & ~flush_in);
        accept      = y_valid_in & y_ready_out;

        a_ins = a_sh_q;
        b_ins = b_sh_q;
        for (int i = 0; i < WORD_W; i++) begin
            if (bit_cnt_q == CW'(i)) begin
                a_ins[i] = dec_a;
                b_ins[i] = dec_b;
            end
        end

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        a_word_d  = a_word_q;
        b_word_d  = b_word_q;
        err_d     = accept & ~good;

        if (state_q == HOLD && word_ready_in)
            state_d = COLLECT;

        if (flush_in && state_q == COLLECT) begin
            bit_cnt_d = '0;
            a_sh_d    = '0;
            b_sh_d    = '0;
        end

        // accept implies ~flush_in, so this never collides with the flush above
        if (accept && good) begin
            if (bit_cnt_q == CW'(WORD_W - 1)) begin
                a_word_d  = a_ins;
                b_word_d  = b_ins;
                bit_cnt_d = '0;
                a_sh_d    = '0;
                b_sh_d    = '0;
                state_d   = HOLD;
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
                a_sh_d    = a_ins;
                b_sh_d    = b_ins;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= COLLECT;
            bit_cnt_q <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            a_word_q  <= '0;
            b_word_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            a_word_q  <= a_word_d;
            b_word_q  <= b_word_d;
            err_q     <= err_d;
        end
    end

`ifdef BITWISE_DEC_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            err_cnt_q <= '0;
        else if (err_d && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign err_cnt_out = err_cnt_q;
`else
    assign err_cnt_out = 16'h0000;
`endif

    assign a_word_out     = a_word_q;
    assign b_word_out     = b_word_q;
    assign word_valid_out = (state_q == HOLD);
    assign err_out        = err_q;

endmodule

// File: tb/tb_bitwise_decoder.sv
// Directed bench for bitwise_decoder: stimulus pushes expected words, a monitor pops them on each word transfer.
module tb_bitwise_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  y_vec = 8'h00;
    logic        y_valid = 1'b0;
    logic        y_ready_out;
    logic        flush = 1'b0;
    logic [7:0]  a_word_out, b_word_out;
    logic        word_valid_out;
    logic        word_ready = 1'b1;
    logic        err_out;
    logic [15:0] err_cnt_out;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];

`ifdef BITWISE_DEC_ERRCNT_EN
    localparam logic [15:0] ERRCNT_ONE = 16'd1;
`else
    localparam logic [15:0] ERRCNT_ONE = 16'd0;
`endif

    bitwise_decoder #(.WORD_W(8)) dut (
        .clk_in(clk), .rst_in(rst), .y_vec_in(y_vec), .y_valid_in(y_valid),
        .y_ready_out(y_ready_out), .flush_in(flush), .a_word_out(a_word_out),
        .b_word_out(b_word_out), .word_valid_out(word_valid_out),
        .word_ready_in(word_ready), .err_out(err_out), .err_cnt_out(err_cnt_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // monitor: a word transfer happens on the next rising edge when valid & ready
    initial begin
        logic [15:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && word_valid_out && word_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL word_unexpected: got a=%h b=%h, none expected", a_word_out, b_word_out);
                end else begin
                    exp = exp_q.pop_front();
                    if ({a_word_out, b_word_out} !== exp) begin
                        fails++;
                        $display("FAIL word: got a=%h b=%h expected a=%h b=%h",
                                 a_word_out, b_word_out, exp[15:8], exp[7:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] v);
        int   n;
        logic r;
        y_vec   = v;
        y_valid = 1'b1;
        n       = 0;
        do begin
            @(negedge clk);
            r = y_ready_out;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 50);
        if (!r) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: ready stayed 0 for vector %h", v);
        end
    endtask

    task automatic burst(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send(v);
        y_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_a_word", 32'(a_word_out), 32'h0);
        chk("rst_b_word", 32'(b_word_out), 32'h0);
        chk("rst_valid", 32'(word_valid_out), 32'h0);
        chk("rst_err", 32'(err_out), 32'h0);
        chk("rst_errcnt", 32'(err_cnt_out), 32'h0);
        #20 rst = 1'b0;
        cycles(1);
        chk("ready_after_rst", 32'(y_ready_out), 32'h1);

        // all-ones word and latency
        exp_q.push_back(16'hFFFF);
        burst(8'h8B, 7);
        chk("valid_before_8th", 32'(word_valid_out), 32'h0);
        burst(8'h8B, 1);
        chk("valid_after_8th", 32'(word_valid_out), 32'h1);
        cycles(2);

        // alternating a/b
        exp_q.push_back(16'h55AA);
        for (int i = 0; i < 4; i++) begin
            send(8'hA6);
            send(8'h36);
        end
        y_valid = 1'b0;
        cycles(2);

        // bad vector dropped
        exp_q.push_back(16'h0000);
        burst(8'h78, 3);
        send(8'h00);
        chk("err_pulse", 32'(err_out), 32'h1);
        chk("err_cnt", 32'(err_cnt_out), 32'(ERRCNT_ONE));
        send(8'h78);
        chk("err_one_cycle", 32'(err_out), 32'h0);
        burst(8'h78, 3);
        chk("no_word_after_7", 32'(word_valid_out), 32'h0);
        burst(8'h78, 1);
        chk("word_after_8_good", 32'(word_valid_out), 32'h1);
        cycles(2);

        // backpressure in HOLD, then release with a simultaneous accept
        word_ready = 1'b0;
        exp_q.push_back(16'hFFFF);
        burst(8'h8B, 8);
        y_vec   = 8'h8B;
        y_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_ready_low", 32'(y_ready_out), 32'h0);
            chk("hold_a_stable", 32'(a_word_out), 32'hFF);
            chk("hold_valid", 32'(word_valid_out), 32'h1);
        end
        @(posedge clk);
        #1;
        word_ready = 1'b1;
        exp_q.push_back(16'h0101);
        send(8'h8B);
        burst(8'h78, 7);
        cycles(2);

        // flush in COLLECT drops the partial word
        burst(8'h78, 5);
        y_vec   = 8'h78;
        y_valid = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        chk("flush_ready_low", 32'(y_ready_out), 32'h0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        y_valid = 1'b0;
        exp_q.push_back(16'hFFFF);
        burst(8'h8B, 3);
        chk("flush_no_leftover", 32'(word_valid_out), 32'h0);
        burst(8'h8B, 5);
        chk("flush_word_valid", 32'(word_valid_out), 32'h1);
        cycles(2);

        // flush in HOLD keeps the held word
        word_ready = 1'b0;
        exp_q.push_back(16'hFF00);
        burst(8'hA6, 8);
        flush   = 1'b1;
        y_vec   = 8'h8B;
        y_valid = 1'b1;
        cycles(2);
        chk("hold_flush_valid", 32'(word_valid_out), 32'h1);
        chk("hold_flush_a", 32'(a_word_out), 32'hFF);
        chk("hold_flush_b", 32'(b_word_out), 32'h00);
        flush      = 1'b0;
        y_valid    = 1'b0;
        word_ready = 1'b1;
        cycles(2);

        // async reset mid-word
        burst(8'h8B, 3);
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_a", 32'(a_word_out), 32'h0);
        chk("rst_mid_valid", 32'(word_valid_out), 32'h0);
        #2 rst = 1'b0;
        cycles(1);

        // async reset in HOLD; the held word is lost
        word_ready = 1'b0;
        burst(8'h8B, 8);
        chk("pre_rst_hold_valid", 32'(word_valid_out), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_hold_a", 32'(a_word_out), 32'h0);
        chk("rst_hold_b", 32'(b_word_out), 32'h0);
        chk("rst_hold_valid", 32'(word_valid_out), 32'h0);
        chk("rst_hold_errcnt", 32'(err_cnt_out), 32'h0);
        #2 rst = 1'b0;
        word_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_rst2", 32'(y_ready_out), 32'h1);
        @(posedge clk);
        #1;
        exp_q.push_back(16'h00FF);
        burst(8'h36, 7);
        chk("fresh_word_not_early", 32'(word_valid_out), 32'h0);
        burst(8'h36, 1);
        cycles(3);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
